// File: rtl/eda_pixel_stack.sv
// LIFO of {i, j} pixel addresses for the region-maximum flood fill: accepts a masked
// 8-neighbour window, serialises its set entries onto the stack, and pops one centre per request.
module eda_pixel_stack #(
    parameter int M            = 4,
    parameter int N            = 4,
    parameter int WINDOW_WIDTH = 9,
    parameter int ADDR_WIDTH   = 4,
    parameter int DEPTH        = M * N,
    parameter int CNT_WIDTH    = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clear,
    input  logic [ADDR_WIDTH-1:0]   upleft_addr,
    input  logic [ADDR_WIDTH-1:0]   up_addr,
    input  logic [ADDR_WIDTH-1:0]   upright_addr,
    input  logic [ADDR_WIDTH-1:0]   left_addr,
    input  logic [ADDR_WIDTH-1:0]   right_addr,
    input  logic [ADDR_WIDTH-1:0]   downleft_addr,
    input  logic [ADDR_WIDTH-1:0]   down_addr,
    input  logic [ADDR_WIDTH-1:0]   downright_addr,
    input  logic [WINDOW_WIDTH-2:0] push_mask,
    input  logic                    push_valid,
    output logic                    push_ready,
    input  logic                    pop_req,
    output logic                    pop_valid,
    output logic [ADDR_WIDTH-1:0]   pop_addr,
    output logic [CNT_WIDTH-1:0]    count,
    output logic                    empty,
    output logic                    full,
    output logic                    overflow
);

    localparam int NB    = WINDOW_WIDTH - 1;
    localparam int SEL_W = (NB > 1) ? $clog2(NB) : 1;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        IDLE,
        DRAIN
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic [NB-1:0]         hold_mask_q, hold_mask_d;
    logic [ADDR_WIDTH-1:0] hold_addr_q [NB];
    logic [ADDR_WIDTH-1:0] hold_addr_d [NB];
    logic                  overflow_q, overflow_d;

    logic [ADDR_WIDTH-1:0] win_addr [NB];
    logic [ADDR_WIDTH-1:0] mem_q [DEPTH];
    logic [SEL_W-1:0]      low_idx;
    logic [NB-1:0]         rest_mask;
    logic                  is_empty, is_full, do_pop, wr_en;
    logic [CNT_WIDTH-1:0]  top_cnt;

    // Mask bit position equals array index: bit 7 upleft down to bit 0 downright.
    assign win_addr[7] = upleft_addr;
    assign win_addr[6] = up_addr;
    assign win_addr[5] = upright_addr;
    assign win_addr[4] = left_addr;
    assign win_addr[3] = right_addr;
    assign win_addr[2] = downleft_addr;
    assign win_addr[1] = down_addr;
    assign win_addr[0] = downright_addr;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CNT_WIDTH'(DEPTH));
    assign top_cnt  = count_q - CNT_WIDTH'(1);

    assign push_ready = (state_q == IDLE);
    assign pop_valid  = (state_q == IDLE) && !is_empty;
    assign pop_addr   = is_empty ? '0 : mem_q[top_cnt[IDX_W-1:0]];
    assign count      = count_q;
    assign empty      = is_empty;
    assign full       = is_full;
    assign overflow   = overflow_q;
    assign do_pop     = pop_req && pop_valid;

    // Lowest set bit drains first, so the highest set bit ends up on top.
    always_comb begin
        low_idx = '0;
        for (int b = NB - 1; b >= 0; b--) begin
            if (hold_mask_q[b]) low_idx = SEL_W'(b);
        end
        rest_mask          = hold_mask_q;
        rest_mask[low_idx] = 1'b0;
    end

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        count_d     = count_q;
        hold_mask_d = hold_mask_q;
        hold_addr_d = hold_addr_q;
        overflow_d  = overflow_q;
        wr_en       = 1'b0;

        if (clear) begin
            state_d     = IDLE;
            count_d     = '0;
            hold_mask_d = '0;
            overflow_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (do_pop) count_d = top_cnt;
                    if (push_valid && (push_mask != '0)) begin
                        hold_mask_d = push_mask;
                        hold_addr_d = win_addr;
                        state_d     = DRAIN;
                    end
                end
                DRAIN: begin
                    if (is_full) begin
                        overflow_d = 1'b1;
                    end else begin
                        wr_en   = 1'b1;
                        count_d = count_q + CNT_WIDTH'(1);
                    end
                    hold_mask_d = rest_mask;
                    if (rest_mask == '0) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            hold_mask_q <= '0;
            hold_addr_q <= '{default: '0};
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            hold_mask_q <= hold_mask_d;
            hold_addr_q <= hold_addr_d;
            overflow_q  <= overflow_d;
        end
    end

    // NOTE: storage has no reset; count_q alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[count_q[IDX_W-1:0]] <= hold_addr_q[low_idx];
    end

endmodule

// File: tb/tb_eda_pixel_stack.sv
// Directed bench for eda_pixel_stack: window drain order, pop order, no-op push,
// overflow at full, clear, push+pop in one cycle, and reset during a drain.
module tb_eda_pixel_stack;

    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int CW    = 5;

    logic          clk, reset_n, clear;
    logic [AW-1:0] win [8];
    logic [7:0]    push_mask;
    logic          push_valid, push_ready, pop_req, pop_valid;
    logic [AW-1:0] pop_addr;
    logic [CW-1:0] count;
    logic          empty, full, overflow;

    int checks   = 0;
    int failures = 0;

    eda_pixel_stack #(
        .M(4), .N(4), .WINDOW_WIDTH(9), .ADDR_WIDTH(AW)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .clear          (clear),
        .upleft_addr    (win[7]),
        .up_addr        (win[6]),
        .upright_addr   (win[5]),
        .left_addr      (win[4]),
        .right_addr     (win[3]),
        .downleft_addr  (win[2]),
        .down_addr      (win[1]),
        .downright_addr (win[0]),
        .push_mask      (push_mask),
        .push_valid     (push_valid),
        .push_ready     (push_ready),
        .pop_req        (pop_req),
        .pop_valid      (pop_valid),
        .pop_addr       (pop_addr),
        .count          (count),
        .empty          (empty),
        .full           (full),
        .overflow       (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_push(input logic [7:0] m);
        push_mask  = m;
        push_valid = 1'b1;
        tick();
        push_valid = 1'b0;
        push_mask  = '0;
        repeat ($countones(m)) tick();
    endtask

    task automatic do_pop();
        pop_req = 1'b1;
        tick();
        pop_req = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (push_ready !== 1'b1) begin failures++; $display("FAIL reset_push_ready got=%b exp=1", push_ready); end
        checks++; if (pop_valid !== 1'b0) begin failures++; $display("FAIL reset_pop_valid got=%b exp=0", pop_valid); end
        checks++; if (pop_addr !== 4'h0) begin failures++; $display("FAIL reset_pop_addr got=%h exp=0", pop_addr); end
        checks++; if (count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    endtask

    task automatic test_two_entry();
        win = '{default: 4'h0};
        win[7] = 4'hA;
        win[0] = 4'hB;
        push_mask  = 8'b1000_0001;
        push_valid = 1'b1;
        tick();
        push_valid = 1'b0;
        checks++; if (push_ready !== 1'b0 || count !== 5'd0) begin failures++; $display("FAIL two_drain0 ready=%b count=%0d exp ready=0 count=0", push_ready, count); end
        tick();
        checks++; if (push_ready !== 1'b0 || count !== 5'd1) begin failures++; $display("FAIL two_drain1 ready=%b count=%0d exp ready=0 count=1", push_ready, count); end
        tick();
        checks++; if (push_ready !== 1'b1 || count !== 5'd2) begin failures++; $display("FAIL two_done ready=%b count=%0d exp ready=1 count=2", push_ready, count); end
        checks++; if (pop_valid !== 1'b1 || pop_addr !== 4'hA) begin failures++; $display("FAIL two_top valid=%b addr=%h exp valid=1 addr=a", pop_valid, pop_addr); end
        do_pop();
        checks++; if (pop_addr !== 4'hB || count !== 5'd1) begin failures++; $display("FAIL two_pop1 addr=%h count=%0d exp addr=b count=1", pop_addr, count); end
        do_pop();
        checks++; if (empty !== 1'b1 || pop_valid !== 1'b0 || pop_addr !== 4'h0) begin failures++; $display("FAIL two_pop2 empty=%b valid=%b addr=%h exp 1 0 0", empty, pop_valid, pop_addr); end
    endtask

    task automatic test_full_window();
        for (int i = 0; i < 8; i++) win[i] = AW'(8 - i);
        push_mask  = 8'hFF;
        push_valid = 1'b1;
        tick();
        push_valid = 1'b0;
        pop_req    = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++; if (push_ready !== 1'b0 || pop_valid !== 1'b0 || count !== CW'(i)) begin failures++; $display("FAIL ff_drain%0d ready=%b valid=%b count=%0d exp 0 0 %0d", i, push_ready, pop_valid, count, i); end
            tick();
        end
        pop_req = 1'b0;
        checks++; if (push_ready !== 1'b1 || count !== 5'd8) begin failures++; $display("FAIL ff_done ready=%b count=%0d exp ready=1 count=8", push_ready, count); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (pop_addr !== AW'(i + 1)) begin failures++; $display("FAIL ff_pop%0d addr=%h exp=%h", i, pop_addr, AW'(i + 1)); end
            do_pop();
        end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL ff_empty got=%b exp=1", empty); end
    endtask

    task automatic test_zero_mask();
        push_mask  = 8'h00;
        push_valid = 1'b1;
        tick();
        push_valid = 1'b0;
        checks++; if (push_ready !== 1'b1 || count !== 5'd0 || pop_valid !== 1'b0) begin failures++; $display("FAIL zero_mask ready=%b count=%0d valid=%b exp 1 0 0", push_ready, count, pop_valid); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 8; i++) win[i] = AW'(i);
        do_push(8'hFF);
        do_push(8'h7F);
        checks++; if (count !== 5'd15 || full !== 1'b0) begin failures++; $display("FAIL ovf_fill count=%0d full=%b exp 15 0", count, full); end
        win[0] = 4'hD;
        win[1] = 4'hE;
        push_mask  = 8'h03;
        push_valid = 1'b1;
        tick();
        push_valid = 1'b0;
        tick();
        checks++; if (count !== 5'd16 || push_ready !== 1'b0 || overflow !== 1'b0) begin failures++; $display("FAIL ovf_mid count=%0d ready=%b ovf=%b exp 16 0 0", count, push_ready, overflow); end
        tick();
        checks++; if (count !== 5'd16 || full !== 1'b1 || overflow !== 1'b1 || push_ready !== 1'b1) begin failures++; $display("FAIL ovf_done count=%0d full=%b ovf=%b ready=%b exp 16 1 1 1", count, full, overflow, push_ready); end
        checks++; if (pop_addr !== 4'hD) begin failures++; $display("FAIL ovf_top addr=%h exp=d", pop_addr); end
        do_clear();
        checks++; if (count !== 5'd0 || overflow !== 1'b0 || full !== 1'b0 || empty !== 1'b1) begin failures++; $display("FAIL ovf_clear count=%0d ovf=%b full=%b empty=%b exp 0 0 0 1", count, overflow, full, empty); end
    endtask

    task automatic test_push_pop_same_cycle();
        win[0] = 4'h8;
        win[1] = 4'h7;
        win[2] = 4'h6;
        do_push(8'h07);
        checks++; if (count !== 5'd3 || pop_addr !== 4'h6) begin failures++; $display("FAIL pp_setup count=%0d addr=%h exp 3 6", count, pop_addr); end
        win[0]     = 4'hC;
        push_mask  = 8'h01;
        push_valid = 1'b1;
        pop_req    = 1'b1;
        tick();
        push_valid = 1'b0;
        pop_req    = 1'b0;
        checks++; if (count !== 5'd2 || push_ready !== 1'b0) begin failures++; $display("FAIL pp_accept count=%0d ready=%b exp 2 0", count, push_ready); end
        tick();
        checks++; if (count !== 5'd3 || pop_addr !== 4'hC) begin failures++; $display("FAIL pp_done count=%0d addr=%h exp 3 c", count, pop_addr); end
        do_pop();
        checks++; if (count !== 5'd2 || pop_addr !== 4'h7) begin failures++; $display("FAIL pp_below count=%0d addr=%h exp 2 7", count, pop_addr); end
        do_clear();
    endtask

    task automatic test_reset_mid_drain();
        for (int i = 0; i < 8; i++) win[i] = AW'(i + 3);
        push_mask  = 8'hFF;
        push_valid = 1'b1;
        tick();
        push_valid = 1'b0;
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        checks++; if (count !== 5'd0 || push_ready !== 1'b1 || empty !== 1'b1) begin failures++; $display("FAIL rst_mid count=%0d ready=%b empty=%b exp 0 1 1", count, push_ready, empty); end
        checks++; if (pop_valid !== 1'b0 || pop_addr !== 4'h0 || overflow !== 1'b0 || full !== 1'b0) begin failures++; $display("FAIL rst_mid_out valid=%b addr=%h ovf=%b full=%b exp 0 0 0 0", pop_valid, pop_addr, overflow, full); end
        tick();
        reset_n = 1'b1;
        tick();
        win[7] = 4'hA;
        win[0] = 4'hB;
        do_push(8'h81);
        checks++; if (count !== 5'd2 || pop_addr !== 4'hA || push_ready !== 1'b1) begin failures++; $display("FAIL rst_after count=%0d addr=%h ready=%b exp 2 a 1", count, pop_addr, push_ready); end
    endtask

    initial begin
        reset_n    = 1'b0;
        clear      = 1'b0;
        push_valid = 1'b0;
        push_mask  = '0;
        pop_req    = 1'b0;
        win        = '{default: 4'h0};
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        test_reset();
        test_two_entry();
        test_full_window();
        test_zero_mask();
        test_overflow();
        test_push_pop_same_cycle();
        test_reset_mid_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
